// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between instruction fetch (IF) and load/store (LS), one transaction in flight.
// Latency: accept, memory request handshake and response take one cycle each at minimum; next accept on cycle 4.
// Backpressure: requester readies are low while a transaction is pending; memory response stalls on owner's rsp_ready.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    // Instruction fetch port (read only)
    input  logic                  i_if_req_valid,
    output logic                  o_if_req_ready,
    input  logic [ADDR_W-1:0]     i_if_req_addr,
    output logic                  o_if_rsp_valid,
    input  logic                  i_if_rsp_ready,
    output logic [DATA_W-1:0]     o_if_rsp_data,

    // Load/store port
    input  logic                  i_ls_req_valid,
    output logic                  o_ls_req_ready,
    input  logic [ADDR_W-1:0]     i_ls_req_addr,
    input  logic                  i_ls_req_we,
    input  logic [DATA_W-1:0]     i_ls_req_wdata,
    input  logic [DATA_W/8-1:0]   i_ls_req_wstrb,
    output logic                  o_ls_rsp_valid,
    input  logic                  i_ls_rsp_ready,
    output logic [DATA_W-1:0]     o_ls_rsp_data,

    // Memory port
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic [ADDR_W-1:0]     o_mem_req_addr,
    output logic                  o_mem_req_we,
    output logic [DATA_W-1:0]     o_mem_req_wdata,
    output logic [DATA_W/8-1:0]   o_mem_req_wstrb,
    input  logic                  i_mem_rsp_valid,
    output logic                  o_mem_rsp_ready,
    input  logic [DATA_W-1:0]     i_mem_rsp_data,

    // Current transaction owner: 0 none, 1 IF, 2 LS
    output logic [1:0]            o_owner
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_LS   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    // Registered copy of the winning request; only this copy ever drives memory,
    // so requesters are free to change their inputs once accepted.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic       last_ls_q, last_ls_d;   // 1 = LS received the most recent grant
    req_t       req_q, req_d;

    logic       grant_if;
    logic       grant_ls;
    logic       owner_rsp_ready;

    // Arbitration between the two requesters; only meaningful while idle.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (i_if_req_valid && i_ls_req_valid) begin
            if (ARB_MODE == 0) begin
                // Fixed priority: load/store always wins a tie.
                grant_ls = 1'b1;
            end else if (last_ls_q) begin
                // Round robin: whoever did not get the last grant goes first.
                grant_if = 1'b1;
            end else begin
                grant_ls = 1'b1;
            end
        end else begin
            grant_if = i_if_req_valid;
            grant_ls = i_ls_req_valid;
        end
    end

    // Ready of whichever requester owns the transaction in flight.
    always_comb begin
        owner_rsp_ready = 1'b0;
        case (owner_q)
            OWN_IF:  owner_rsp_ready = i_if_rsp_ready;
            OWN_LS:  owner_rsp_ready = i_ls_rsp_ready;
            default: owner_rsp_ready = 1'b0;
        endcase
    end

    // Next-state, request capture and handshake outputs.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_ls_d       = last_ls_q;
        req_d           = req_q;
        o_if_req_ready  = 1'b0;
        o_ls_req_ready  = 1'b0;
        o_mem_req_valid = 1'b0;
        o_mem_rsp_ready = 1'b0;
        o_if_rsp_valid  = 1'b0;
        o_ls_rsp_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Readies are held low during reset: the flops are about to be
                // cleared, so an accept here would silently lose the request.
                if (!rst) begin
                    o_if_req_ready = grant_if;
                    o_ls_req_ready = grant_ls;
                    if (grant_ls) begin
                        req_d.addr  = i_ls_req_addr;
                        req_d.we    = i_ls_req_we;
                        req_d.wdata = i_ls_req_wdata;
                        req_d.wstrb = i_ls_req_wstrb;
                        owner_d     = OWN_LS;
                        last_ls_d   = 1'b1;
                        state_d     = ST_REQ;
                    end else if (grant_if) begin
                        // Fetch is read only: force a read with no byte enables.
                        req_d.addr  = i_if_req_addr;
                        req_d.we    = 1'b0;
                        req_d.wdata = '0;
                        req_d.wstrb = '0;
                        owner_d     = OWN_IF;
                        last_ls_d   = 1'b0;
                        state_d     = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                // Valid stays high until memory takes the request.
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    state_d = ST_RSP;
                end
            end

            ST_RSP: begin
                // Response is passed straight through to the owner; memory is
                // only told "ready" when the owner itself can take the data.
                o_mem_rsp_ready = owner_rsp_ready;
                o_if_rsp_valid  = (owner_q == OWN_IF) && i_mem_rsp_valid;
                o_ls_rsp_valid  = (owner_q == OWN_LS) && i_mem_rsp_valid;
                if (i_mem_rsp_valid && owner_rsp_ready) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                end
            end

            default: begin
                // Unreachable encoding: recover to idle with every handshake low.
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // State, owner, grant history and request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            last_ls_q <= 1'b1;      // first round-robin tie goes to IF
            req_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_ls_q <= last_ls_d;
            req_q     <= req_d;
        end
    end

    assign o_mem_req_addr  = req_q.addr;
    assign o_mem_req_we    = req_q.we;
    assign o_mem_req_wdata = req_q.wdata;
    assign o_mem_req_wstrb = req_q.wstrb;

    // Data buses are shared pass-throughs; the per-port valids qualify them.
    assign o_if_rsp_data   = i_mem_rsp_data;
    assign o_ls_rsp_data   = i_mem_rsp_data;

    assign o_owner         = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: checks two arbiters (round robin and fixed priority) fed identical stimulus.
// Latency: inputs change on the falling edge, outputs are compared 1-2 time units later.
// Backpressure: memory and requester readies are driven directly, both directed and random.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus
    logic          rst;
    logic          if_req_valid;
    logic [AW-1:0] if_req_addr;
    logic          if_rsp_ready;
    logic          ls_req_valid;
    logic [AW-1:0] ls_req_addr;
    logic          ls_req_we;
    logic [DW-1:0] ls_req_wdata;
    logic [SW-1:0] ls_req_wstrb;
    logic          ls_rsp_ready;
    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;

    // Per-instance outputs: index 0 = round robin, index 1 = fixed priority
    logic [1:0]    if_req_ready;
    logic [1:0]    ls_req_ready;
    logic [1:0]    if_rsp_valid;
    logic [1:0]    ls_rsp_valid;
    logic [1:0]    mem_req_valid;
    logic [1:0]    mem_req_we;
    logic [1:0]    mem_rsp_ready;
    logic [DW-1:0] if_rsp_data   [2];
    logic [DW-1:0] ls_rsp_data   [2];
    logic [AW-1:0] mem_req_addr  [2];
    logic [DW-1:0] mem_req_wdata [2];
    logic [SW-1:0] mem_req_wstrb [2];
    logic [1:0]    owner         [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W   (AW),
            .DATA_W   (DW),
            .ARB_MODE ((g == 0) ? 1 : 0)
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .i_if_req_valid  (if_req_valid),
            .o_if_req_ready  (if_req_ready[g]),
            .i_if_req_addr   (if_req_addr),
            .o_if_rsp_valid  (if_rsp_valid[g]),
            .i_if_rsp_ready  (if_rsp_ready),
            .o_if_rsp_data   (if_rsp_data[g]),
            .i_ls_req_valid  (ls_req_valid),
            .o_ls_req_ready  (ls_req_ready[g]),
            .i_ls_req_addr   (ls_req_addr),
            .i_ls_req_we     (ls_req_we),
            .i_ls_req_wdata  (ls_req_wdata),
            .i_ls_req_wstrb  (ls_req_wstrb),
            .o_ls_rsp_valid  (ls_rsp_valid[g]),
            .i_ls_rsp_ready  (ls_rsp_ready),
            .o_ls_rsp_data   (ls_rsp_data[g]),
            .o_mem_req_valid (mem_req_valid[g]),
            .i_mem_req_ready (mem_req_ready),
            .o_mem_req_addr  (mem_req_addr[g]),
            .o_mem_req_we    (mem_req_we[g]),
            .o_mem_req_wdata (mem_req_wdata[g]),
            .o_mem_req_wstrb (mem_req_wstrb[g]),
            .i_mem_rsp_valid (mem_rsp_valid),
            .o_mem_rsp_ready (mem_rsp_ready[g]),
            .i_mem_rsp_data  (mem_rsp_data),
            .o_owner         (owner[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level reference: is a transaction open, has memory taken
    // the request yet, who owns it, and what was captured.
    int            mode    [2] = '{1, 0};
    bit            m_busy  [2];
    bit            m_acked [2];
    int            m_own   [2];
    int            m_last  [2];
    logic [AW-1:0] m_addr  [2];
    logic          m_we    [2];
    logic [DW-1:0] m_wdata [2];
    logic [SW-1:0] m_wstrb [2];

    int g_rr[$];
    int g_fp[$];
    int o_rr[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int d);
        m_busy[d]  = 1'b0;
        m_acked[d] = 1'b0;
        m_own[d]   = 0;
        m_last[d]  = 2;
        m_addr[d]  = '0;
        m_we[d]    = 1'b0;
        m_wdata[d] = '0;
        m_wstrb[d] = '0;
    endtask

    // Compare one instance against the reference for the current inputs,
    // then advance the reference by one clock edge.
    task automatic model_cycle(input int d);
        int win;
        bit exp_mreq, sel_rdy, exp_mrdy, exp_ifv, exp_lsv;
        win = 0;
        if (!m_busy[d] && !rst) begin
            if (if_req_valid && ls_req_valid)
                win = (mode[d] == 0) ? 2 : ((m_last[d] == 2) ? 1 : 2);
            else if (if_req_valid)
                win = 1;
            else if (ls_req_valid)
                win = 2;
        end
        exp_mreq = m_busy[d] && !m_acked[d];
        sel_rdy  = (m_own[d] == 1) ? if_rsp_ready : ((m_own[d] == 2) ? ls_rsp_ready : 1'b0);
        exp_mrdy = m_busy[d] && m_acked[d] && sel_rdy;
        exp_ifv  = m_busy[d] && m_acked[d] && (m_own[d] == 1) && mem_rsp_valid;
        exp_lsv  = m_busy[d] && m_acked[d] && (m_own[d] == 2) && mem_rsp_valid;

        chk($sformatf("if_req_ready[%0d]", d), if_req_ready[d], win == 1);
        chk($sformatf("ls_req_ready[%0d]", d), ls_req_ready[d], win == 2);
        chk($sformatf("mem_req_valid[%0d]", d), mem_req_valid[d], exp_mreq);
        chk($sformatf("mem_rsp_ready[%0d]", d), mem_rsp_ready[d], exp_mrdy);
        chk($sformatf("if_rsp_valid[%0d]", d), if_rsp_valid[d], exp_ifv);
        chk($sformatf("ls_rsp_valid[%0d]", d), ls_rsp_valid[d], exp_lsv);
        chk($sformatf("owner[%0d]", d), owner[d], m_busy[d] ? m_own[d] : 0);
        if (exp_mreq) begin
            chk($sformatf("mem_req_addr[%0d]", d), mem_req_addr[d], m_addr[d]);
            chk($sformatf("mem_req_we[%0d]", d), mem_req_we[d], m_we[d]);
            chk($sformatf("mem_req_wstrb[%0d]", d), mem_req_wstrb[d], m_wstrb[d]);
            if (m_we[d])
                chk($sformatf("mem_req_wdata[%0d]", d), mem_req_wdata[d], m_wdata[d]);
        end
        if (exp_ifv)
            chk($sformatf("if_rsp_data[%0d]", d), if_rsp_data[d], mem_rsp_data);
        if (exp_lsv && !m_we[d])
            chk($sformatf("ls_rsp_data[%0d]", d), ls_rsp_data[d], mem_rsp_data);

        if (rst) begin
            model_clear(d);
        end else if (win != 0) begin
            m_busy[d]  = 1'b1;
            m_acked[d] = 1'b0;
            m_own[d]   = win;
            m_last[d]  = win;
            if (win == 2) begin
                m_addr[d]  = ls_req_addr;
                m_we[d]    = ls_req_we;
                m_wdata[d] = ls_req_wdata;
                m_wstrb[d] = ls_req_wstrb;
            end else begin
                m_addr[d]  = if_req_addr;
                m_we[d]    = 1'b0;
                m_wdata[d] = '0;
                m_wstrb[d] = '0;
            end
        end else if (exp_mreq && mem_req_ready) begin
            m_acked[d] = 1'b1;
        end else if (exp_mrdy && mem_rsp_valid) begin
            m_busy[d] = 1'b0;
            m_own[d]  = 0;
        end
    endtask

    // One clock: settle, compare both instances, step to the next falling edge.
    task automatic tick();
        #1;
        model_cycle(0);
        model_cycle(1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        rst           = 1'b0;
        if_req_valid  = 1'b0;
        if_req_addr   = '0;
        if_rsp_ready  = 1'b0;
        ls_req_valid  = 1'b0;
        ls_req_addr   = '0;
        ls_req_we     = 1'b0;
        ls_req_wdata  = '0;
        ls_req_wstrb  = '0;
        ls_rsp_ready  = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        quiet_inputs();
        rst = 1'b1;
        model_clear(0);
        model_clear(1);
        @(posedge clk);
        @(negedge clk);

        // Reset state
        do_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset owner", owner[d], 0);
            chk("reset mem_req_valid", mem_req_valid[d], 0);
            chk("reset mem_rsp_ready", mem_rsp_ready[d], 0);
        end
        tick();

        // IF-only read with an immediately responding memory
        do_reset();
        if_req_valid  = 1'b1;
        if_req_addr   = 32'h0000_0010;
        if_rsp_ready  = 1'b1;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        #1 chk("s1 c0 if_req_ready", if_req_ready[0], 1);
        tick();
        if_req_valid = 1'b0;
        #1;
        chk("s1 c1 mem_req_valid", mem_req_valid[0], 1);
        chk("s1 c1 mem_req_addr", mem_req_addr[0], 32'h10);
        chk("s1 c1 mem_req_we", mem_req_we[0], 0);
        tick();
        #1;
        chk("s1 c2 if_rsp_valid", if_rsp_valid[0], 1);
        chk("s1 c2 if_rsp_data", if_rsp_data[0], 32'hDEAD_BEEF);
        tick();
        #1 chk("s1 c3 owner", owner[0], 0);
        tick();

        // Both requesters hammering: round robin alternates, fixed priority starves IF
        do_reset();
        if_req_valid  = 1'b1;
        if_req_addr   = 32'h40;
        ls_req_valid  = 1'b1;
        ls_req_addr   = 32'h200;
        if_rsp_ready  = 1'b1;
        ls_rsp_ready  = 1'b1;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h5555_AAAA;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (if_req_ready[0]) g_rr.push_back(1);
            if (ls_req_ready[0]) g_rr.push_back(2);
            if (if_req_ready[1]) g_fp.push_back(1);
            if (ls_req_ready[1]) g_fp.push_back(2);
            if (mem_req_valid[0]) o_rr.push_back(int'(owner[0]));
            tick();
        end
        chk("s2 rr grant count", g_rr.size(), 4);
        chk("s2 fp grant count", g_fp.size(), 4);
        chk("s2 rr owner count", o_rr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s2 rr grant %0d", i), (i < g_rr.size()) ? g_rr[i] : 0, (i % 2 == 0) ? 1 : 2);
            chk($sformatf("s2 rr owner %0d", i), (i < o_rr.size()) ? o_rr[i] : 0, (i % 2 == 0) ? 1 : 2);
            chk($sformatf("s2 fp grant %0d", i), (i < g_fp.size()) ? g_fp[i] : 0, 2);
        end

        // LS write held in REQ by a slow memory; IF waits until idle
        do_reset();
        ls_req_valid  = 1'b1;
        ls_req_we     = 1'b1;
        ls_req_addr   = 32'h100;
        ls_req_wdata  = 32'h1234_5678;
        ls_req_wstrb  = 4'h3;
        ls_rsp_ready  = 1'b1;
        if_rsp_ready  = 1'b1;
        #1 chk("s3 ls accept rr", ls_req_ready[0], 1);
        chk("s3 ls accept fp", ls_req_ready[1], 1);
        tick();
        ls_req_valid = 1'b0;
        ls_req_we    = 1'b0;
        ls_req_addr  = $urandom;
        ls_req_wdata = $urandom;
        ls_req_wstrb = 4'($urandom);
        if_req_valid = 1'b1;
        if_req_addr  = 32'h80;
        for (int c = 0; c < 5; c++) begin
            mem_req_ready = (c == 4);
            #1;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("s3 req%0d valid", c), mem_req_valid[d], 1);
                chk($sformatf("s3 req%0d addr", c), mem_req_addr[d], 32'h100);
                chk($sformatf("s3 req%0d we", c), mem_req_we[d], 1);
                chk($sformatf("s3 req%0d wdata", c), mem_req_wdata[d], 32'h1234_5678);
                chk($sformatf("s3 req%0d wstrb", c), mem_req_wstrb[d], 4'h3);
                chk($sformatf("s3 req%0d if blocked", c), if_req_ready[d], 0);
            end
            tick();
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = $urandom;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("s3 ls ack", ls_rsp_valid[d], 1);
            chk("s3 if blocked in rsp", if_req_ready[d], 0);
        end
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) chk("s3 if granted after idle", if_req_ready[d], 1);
        tick();
        if_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        tick();
        tick();
        tick();

        // Owner not ready: response waits in RSP until IF takes it
        do_reset();
        if_req_valid  = 1'b1;
        if_req_addr   = 32'h44;
        mem_req_ready = 1'b1;
        tick();
        if_req_valid = 1'b0;
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hCAFE_F00D;
        if_rsp_ready  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("s4 stall%0d mem_rsp_ready", c), mem_rsp_ready[0], 0);
            chk($sformatf("s4 stall%0d owner", c), owner[0], 1);
            tick();
        end
        if_rsp_ready = 1'b1;
        #1 chk("s4 release mem_rsp_ready", mem_rsp_ready[0], 1);
        tick();
        mem_rsp_valid = 1'b0;
        #1 chk("s4 done owner", owner[0], 0);
        tick();

        // Reset in the middle of REQ drops the transaction
        do_reset();
        if_req_valid = 1'b1;
        if_req_addr  = 32'h88;
        tick();
        if_req_valid = 1'b0;
        #1 chk("s5 in req", mem_req_valid[0], 1);
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = 32'h8C;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("s5 owner cleared", owner[d], 0);
            chk("s5 mem_req_valid cleared", mem_req_valid[d], 0);
            chk("s5 new if granted", if_req_ready[d], 1);
        end
        tick();
        if_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        #1 chk("s5 new addr", mem_req_addr[0], 32'h8C);
        tick();
        mem_rsp_valid = 1'b1;
        if_rsp_ready  = 1'b1;
        tick();
        do_reset();

        // Random traffic against the reference
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(63) == 0);
            if_req_valid  = ($urandom_range(2) != 0);
            if_req_addr   = $urandom;
            if_rsp_ready  = ($urandom_range(3) != 0);
            ls_req_valid  = ($urandom_range(2) != 0);
            ls_req_addr   = $urandom;
            ls_req_we     = 1'($urandom);
            ls_req_wdata  = $urandom;
            ls_req_wstrb  = 4'($urandom);
            ls_rsp_ready  = ($urandom_range(3) != 0);
            mem_req_ready = 1'($urandom);
            mem_rsp_valid = 1'($urandom);
            mem_rsp_data  = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the fetch unit (IF) and the load/store path of the execute unit (LS).
- Sits between the fetch/execute units and the memory interface. Allows exactly one outstanding transaction at a time.
- Arbitrates on valid/ready request channels, registers the winning request, drives it to memory, then routes the memory response back to the owner.
- Default: round-robin; fixed priority (LS over IF) is selectable.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- ARB_MODE, 1, 0 = fixed priority (LS wins ties), 1 = round-robin.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_if_req_valid  input  1  IF read request
- o_if_req_ready  output  1  IF request accepted this cycle
- i_if_req_addr  input  ADDR_W  IF fetch address
- o_if_rsp_valid  output  1  IF read data valid
- i_if_rsp_ready  input  1  IF accepts response
- o_if_rsp_data  output  DATA_W  IF read data
- i_ls_req_valid  input  1  LS request
- o_ls_req_ready  output  1  LS request accepted this cycle
- i_ls_req_addr  input  ADDR_W  LS address
- i_ls_req_we  input  1  1 = write
- i_ls_req_wdata  input  DATA_W  write data
- i_ls_req_wstrb  input  DATA_W/8  byte enables
- o_ls_rsp_valid  output  1  LS response valid (read data or write ack)
- i_ls_rsp_ready  input  1  LS accepts response
- o_ls_rsp_data  output  DATA_W  LS read data
- o_mem_req_valid / i_mem_req_ready  output/input  1  memory request handshake
- o_mem_req_addr, o_mem_req_we, o_mem_req_wdata, o_mem_req_wstrb  output  ADDR_W/1/DATA_W/DATA_W/8  registered request
- i_mem_rsp_valid / o_mem_rsp_ready  input/output  1  memory response handshake
- i_mem_rsp_data  input  DATA_W  memory read data
- o_owner  output  2  0 = none, 1 = IF, 2 = LS (current transaction owner)

Behaviour:
- **States:** IDLE, REQ, RSP. Reset (rst=1 at clk edge) forces IDLE.
  - Reset also clears the request registers, sets owner=none, and sets last_grant=LS, so the first round-robin tie goes to IF.
- **IDLE:**
  - Winner is chosen among the asserted valids. Its req_ready is driven combinationally high for that cycle only; the loser's ready is 0.
  - On the accept edge, the winner's addr/we/wdata/wstrb are latched (IF forces we=0, wstrb=0). owner=winner, last_grant=winner, next state is REQ.
  - No valids: stay in IDLE, all readies 0.
- **Arbitration:**
  - ARB_MODE=0: LS wins any tie.
  - ARB_MODE=1: on a tie, the requester that is not last_grant wins. A single requester always wins.
- **REQ:** o_mem_req_valid=1 with registered fields held stable. On i_mem_req_ready=1, go to RSP. Valid must not drop while unacknowledged.
- **RSP:**
  - o_mem_rsp_ready = owner's rsp_ready.
  - Owner's rsp_valid = i_mem_rsp_valid and rsp_data = i_mem_rsp_data, combinational pass-through. The non-owner's rsp_valid is 0.
  - On the i_mem_rsp_valid & o_mem_rsp_ready handshake, go to IDLE and set owner=none.
  - Write transactions also complete via a memory response (ack); its data is don't-care.
- **Outputs when not in their state:** o_mem_req_valid=0 outside REQ; o_mem_rsp_ready=0 outside RSP. Stray memory responses in IDLE/REQ are not accepted.
- **Timing:**
  - Minimum transaction is 3 cycles: accept (IDLE), request handshake (REQ), response (RSP). Next accept is possible on the 4th cycle.
  - No request is accepted while REQ or RSP is pending.
- **Reset outputs:** o_*_req_ready=0, o_*_rsp_valid=0, o_mem_req_valid=0, o_mem_rsp_ready=0, o_owner=0.
- **Reset mid-transaction:** returns to IDLE the next cycle and the transaction is dropped. The memory side is reset by the same rst.
- **Illegal state encoding:** next state IDLE, all handshake outputs 0.
- **Requester input stability:** requester inputs may change freely after acceptance, since only registered copies drive memory.

Test Plan:
- IF only, addr 0x0000_0010, mem_req_ready and rsp_valid immediate with data 0xDEAD_BEEF -> if_req_ready pulses cycle 0, mem_req_valid cycle 1 with addr 0x10/we=0, if_rsp_valid with 0xDEADBEEF cycle 2, IDLE cycle 3.
- IF and LS both valid every cycle, ARB_MODE=1 -> grants alternate IF, LS, IF, LS; o_owner sequence 1,2,1,2.
- Same stimulus, ARB_MODE=0 -> LS granted every transaction; IF never granted while LS valid.
- LS write addr 0x100, wdata 0x1234_5678, wstrb 0x3; mem_req_ready held low 4 cycles -> mem_req fields stable for all 5 REQ cycles; ls_rsp_valid on ack; no IF grant until IDLE.
- RSP with i_if_rsp_ready=0 for 3 cycles while i_mem_rsp_valid=1 -> o_mem_rsp_ready=0, state held in RSP; completes the cycle i_if_rsp_ready rises.
- rst=1 during REQ -> next cycle all outputs at reset values, o_owner=0; a following IF request is granted normally.
